bk_addsub_pipe: RTL
===================

Name: bk_addsub_pipe

Overview:
- Parametrised, pipelined successor to the 16-bit Brent-Kung adder.
- Computes a+b+cin or a-b-bin over WIDTH bits using a Brent-Kung prefix carry network.
- The datapath is split into three registered stages with a valid/ready handshake, so it drops into streaming datapaths where the downstream consumer can stall.
- Emits a carry-out, signed overflow, zero flag and a pass-through tag with every result.

Parameters:
- WIDTH, 32: operand width; power of two, 4..64; anything else is a compile-time error.
- TAG_W, 4: width of the sideband tag carried alongside each operation; minimum 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept an input this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in (add) or borrow-in (sub).
- in_sub  in  1  0 = add, 1 = subtract.
- in_tag  in  TAG_W  sideband tag, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH  result.
- out_cout  out  1  raw carry-out of the MSB.
- out_ovf  out  1  two's-complement signed overflow.
- out_zero  out  1  out_sum == 0.
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Reset, asynchronous active-high: all stage valid bits clear; out_valid=0; out_sum, out_cout, out_ovf, out_tag = 0; out_zero = 1 (consistent with sum = 0). in_ready = 1 from the first cycle after reset deasserts. Any in-flight operations are discarded, with no partial output.
- Operand conditioning:
  - Add: B' = in_b, c0 = in_cin.
  - Sub: B' = ~in_b, c0 = ~in_cin, giving a - b - in_cin with borrow semantics.
- Stage S1 (capture + first-order terms): registers p = a^B', g = a&B', c0, a[MSB], B'[MSB], in_sub and in_tag.
- Stage S2 (prefix tree):
  - Brent-Kung up-sweep: log2(WIDTH) levels of group (G,P) over 2, 4, ... WIDTH bits.
  - Down-sweep: log2(WIDTH)-1 levels filling the remaining carries, each combined with c0 as c[k] = G[k-1:0] | P[k-1:0]&c0.
  - Registers c[WIDTH:0] and p.
- Stage S3 (sum + flags):
  - out_sum = p ^ c[WIDTH-1:0].
  - out_cout = c[WIDTH].
  - out_ovf = c[WIDTH] ^ c[WIDTH-1].
  - out_zero = ~|out_sum.
- Latency: exactly 3 cycles from input handshake to out_valid when unstalled. Throughput is 1 operation per cycle.
- Handshake:
  - An input transfer occurs when in_valid & in_ready; an output transfer occurs when out_valid & out_ready.
  - Each stage k loads when its valid bit is 0 or stage k+1 loads; S3 loads when out_valid=0 or out_ready=1.
  - in_ready = S1 load enable. It is combinational from out_ready through the chain, with no registered skid.
  - A stalled stage holds its data and valid unchanged.
  - out_* is stable while out_valid=1 and out_ready=0.
- Bubbles: a stage with valid=0 always loads, so a pipeline with gaps compresses under stall. Up to 3 operations are held when fully stalled.
- Simultaneous in and out transfer when full: allowed; the pipeline shifts by one with no loss or duplication.
- in_* is ignored when in_valid=0; data registers may update, but valid bits must not.
- Ordering: results leave in input order; the tag is never reordered.
- Arithmetic is modulo 2^WIDTH; out_cout is not inverted for sub, so borrow-out = ~out_cout.

Test Plan:
- WIDTH=32 add: a=0xFFFF_FFFF, b=0x0000_0001, cin=0, tag=3 -> 3 cycles later sum=0, cout=1, ovf=0, zero=1, tag=3.
- Signed overflow: add 0x7FFF_FFFF + 1 -> sum=0x8000_0000, ovf=1, cout=0. Sub 0x8000_0000 - 1 with cin=0 -> sum=0x7FFF_FFFF, ovf=1, cout=1.
- Sub with borrow: a=5, b=7, cin=1 -> sum=0xFFFF_FFFD, cout=0, ovf=0, zero=0.
- Backpressure: stream tags 0..9 back-to-back with out_ready=0 for cycles 4-8.
  - in_ready drops once 3 operations are held.
  - out_* holds stable during the stall.
  - All 10 results arrive in order with no drop or duplicate, each matching a reference model.
- Reset mid-operation: assert rst with 3 operations in flight -> out_valid=0 immediately (asynchronously); after release no stale result appears; a new operation completes in 3 cycles.
- Random regression for WIDTH in {4, 16, 64}: 10k random add/sub operations with random in_valid/out_ready -> every result bit-exact against a behavioural model; 100% of the operations issued are received.

Source files
------------

// File: rtl/bk_addsub_pipe.sv
// Three-stage pipelined WIDTH-bit adder/subtractor built on a Brent-Kung prefix carry network,
// with a valid/ready handshake that lets downstream stalls propagate back to the input.
module bk_addsub_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LOG = $clog2(WIDTH);

    if (WIDTH < 4 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("bk_addsub_pipe: WIDTH must be a power of two in 4..64");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("bk_addsub_pipe: TAG_W must be at least 1");
    end

    // Stage registers
    logic             r1_valid, r2_valid, r3_valid;
    logic [WIDTH-1:0] r1_p, r1_g;
    logic             r1_c0;
    logic [TAG_W-1:0] r1_tag, r2_tag, r3_tag;
    logic [WIDTH:0]   r2_c;
    logic [WIDTH-1:0] r2_p;
    logic [WIDTH-1:0] r3_sum;
    logic             r3_cout, r3_ovf, r3_zero;

    logic             w_ld1, w_ld2, w_ld3;
    logic [WIDTH-1:0] w_bx;
    logic             w_c0;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH:0]   w_c;

    // Load enables ripple back combinationally from the consumer; an empty stage always loads.
    assign w_ld3    = ~r3_valid | out_ready;
    assign w_ld2    = ~r2_valid | w_ld3;
    assign w_ld1    = ~r1_valid | w_ld2;
    assign in_ready = w_ld1;

    assign w_bx = in_b ^ {WIDTH{in_sub}};
    assign w_c0 = in_cin ^ in_sub;

    // Up-sweep: level l merges groups of 2^l bits into groups of 2^(l+1).
    logic [WIDTH-1:0] w_ug [LOG+1];
    logic [WIDTH-1:0] w_up [LOG+1];
    assign w_ug[0] = r1_g;
    assign w_up[0] = r1_p;

    for (genvar l = 0; l < LOG; l++) begin : g_up
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (((i + 1) % (2 ** (l + 1))) == 0) begin : g_node
                assign w_ug[l+1][i] = w_ug[l][i] | (w_up[l][i] & w_ug[l][i-(2**l)]);
                assign w_up[l+1][i] = w_up[l][i] & w_up[l][i-(2**l)];
            end else begin : g_pass
                assign w_ug[l+1][i] = w_ug[l][i];
                assign w_up[l+1][i] = w_up[l][i];
            end
        end
    end

    // Down-sweep: fill the prefixes the up-sweep left partial, largest stride first.
    logic [WIDTH-1:0] w_dg [LOG];
    logic [WIDTH-1:0] w_dp [LOG];
    assign w_dg[0] = w_ug[LOG];
    assign w_dp[0] = w_up[LOG];

    for (genvar j = 0; j < LOG - 1; j++) begin : g_down
        localparam int STEP = 2 ** (LOG - 2 - j);
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if ((i >= 3 * STEP - 1) && (((i + 1) % (2 * STEP)) == STEP)) begin : g_node
                assign w_dg[j+1][i] = w_dg[j][i] | (w_dp[j][i] & w_dg[j][i-STEP]);
                assign w_dp[j+1][i] = w_dp[j][i] & w_dp[j][i-STEP];
            end else begin : g_pass
                assign w_dg[j+1][i] = w_dg[j][i];
                assign w_dp[j+1][i] = w_dp[j][i];
            end
        end
    end

    assign w_c   = {w_dg[LOG-1] | (w_dp[LOG-1] & {WIDTH{r1_c0}}), r1_c0};
    assign w_sum = r2_p ^ r2_c[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r1_p     <= '0;
            r1_g     <= '0;
            r1_c0    <= 1'b0;
            r1_tag   <= '0;
        end else if (w_ld1) begin
            r1_valid <= in_valid;
            r1_p     <= in_a ^ w_bx;
            r1_g     <= in_a & w_bx;
            r1_c0    <= w_c0;
            r1_tag   <= in_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_valid <= 1'b0;
            r2_c     <= '0;
            r2_p     <= '0;
            r2_tag   <= '0;
        end else if (w_ld2) begin
            r2_valid <= r1_valid;
            r2_c     <= w_c;
            r2_p     <= r1_p;
            r2_tag   <= r1_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r3_valid <= 1'b0;
            r3_sum   <= '0;
            r3_cout  <= 1'b0;
            r3_ovf   <= 1'b0;
            r3_zero  <= 1'b1;
            r3_tag   <= '0;
        end else if (w_ld3) begin
            r3_valid <= r2_valid;
            r3_sum   <= w_sum;
            r3_cout  <= r2_c[WIDTH];
            r3_ovf   <= r2_c[WIDTH] ^ r2_c[WIDTH-1];
            r3_zero  <= ~|w_sum;
            r3_tag   <= r2_tag;
        end
    end

    assign out_valid = r3_valid;
    assign out_sum   = r3_sum;
    assign out_cout  = r3_cout;
    assign out_ovf   = r3_ovf;
    assign out_zero  = r3_zero;
    assign out_tag   = r3_tag;

endmodule
